// File: rtl/psum_accumulator_if.sv
// Handshake and data bundle between an upstream multiplier switch, the
// partial-sum accumulator and its downstream consumer.
interface psum_accumulator_if #(
   parameter int IN_W  = 24,
   parameter int ACC_W = 32,
   parameter int LEN_W = 8
);
   logic             i_cfg_valid;
   logic [LEN_W-1:0] i_cfg_len;
   logic             i_valid;
   logic [IN_W-1:0]  i_data;
   logic             i_ready;
   logic             o_valid;
   logic [ACC_W-1:0] o_data;
   logic             o_busy;
   logic             o_err;

   // Accumulator side.
   modport slave (
      input  i_cfg_valid, i_cfg_len, i_valid, i_data, i_ready,
      output o_valid, o_data, o_busy, o_err
   );

   // Driver side (upstream producer plus downstream consumer).
   modport master (
      output i_cfg_valid, i_cfg_len, i_valid, i_data, i_ready,
      input  o_valid, o_data, o_busy, o_err
   );
endinterface

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums fixed-length groups of unsigned products
// and hands each group total to a single-entry result register.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no group length loaded; products are ignored
//   RUN   | length loaded; products accumulate, groups complete on count
module psum_accumulator #(
   parameter int IN_W  = 24,
   parameter int ACC_W = 32,
   parameter int LEN_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   psum_accumulator_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [LEN_W:0]   len_q;
   logic [LEN_W:0]   count_q;
   logic [LEN_W:0]   count_inc;
   logic [LEN_W:0]   cfg_len_eff;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] o_data_q;
   logic             o_valid_q;
   logic             o_err_q;
   logic             cfg_accept;
   logic             cfg_reject;
   logic             prod_accept;
   logic             group_done;
   logic             xfer;
   logic             drop;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and per-cycle accept decisions; config beats a product at count 0.
   always_comb begin
      state_d     = state_q;
      cfg_accept  = 1'b0;
      cfg_reject  = 1'b0;
      prod_accept = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_cfg_valid) begin
               cfg_accept = 1'b1;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (bus.i_cfg_valid) begin
               if (count_q == '0) cfg_accept = 1'b1;
               else               cfg_reject = 1'b1;
            end
            prod_accept = bus.i_valid && !cfg_accept;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath decode: group completion, downstream transfer and overflow drop.
   always_comb begin
      count_inc   = count_q + (LEN_W+1)'(1);
      sum         = acc_q + ACC_W'(bus.i_data);
      group_done  = prod_accept && (count_inc == len_q);
      xfer        = o_valid_q && bus.i_ready;
      drop        = group_done && o_valid_q && !bus.i_ready;
      cfg_len_eff = (bus.i_cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                          : {1'b0, bus.i_cfg_len};
   end

   // Length, count and running sum; a completing product restarts the group at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q   <= '0;
         count_q <= '0;
         acc_q   <= '0;
      end else if (cfg_accept) begin
         len_q   <= cfg_len_eff;
         count_q <= '0;
         acc_q   <= '0;
      end else if (prod_accept) begin
         if (group_done) begin
            count_q <= '0;
            acc_q   <= '0;
         end else begin
            count_q <= count_inc;
            acc_q   <= sum;
         end
      end
   end

   // Single-entry result register; a new sum may replace a result leaving this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
      end else if (group_done && (!o_valid_q || xfer)) begin
         o_valid_q <= 1'b1;
         o_data_q  <= sum;
      end else if (xfer) begin
         o_valid_q <= 1'b0;
      end
   end

   // Sticky error: dropped group result or config arriving mid-group.
   always_ff @(posedge clk) begin
      if (rst)                      o_err_q <= 1'b0;
      else if (drop || cfg_reject)  o_err_q <= 1'b1;
   end

   assign bus.o_valid = o_valid_q;
   assign bus.o_data  = o_data_q;
   assign bus.o_busy  = (count_q != '0);
   assign bus.o_err   = o_err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: directed scenarios plus a
// randomized run, all compared against a group-level reference model.
module tb_psum_accumulator;

   logic clk;
   logic rst;

   psum_accumulator_if #(.IN_W(24), .ACC_W(32), .LEN_W(8)) bus ();

   psum_accumulator #(.IN_W(24), .ACC_W(32), .LEN_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // Reference model: a loaded length, the products of the open group, one result slot.
   bit          m_have;
   int          m_len;
   int unsigned m_grp[$];
   bit          m_ov;
   bit [31:0]   m_od;
   bit          m_err;

   task automatic chk(string tag, longint got, longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(bit r, bit cv, int cl, bit v, int unsigned d, bit rdy);
      bit     xfer;
      bit     done;
      longint s;
      if (r) begin
         m_have = 0; m_len = 0; m_grp.delete();
         m_ov = 0; m_od = 0; m_err = 0;
         return;
      end
      xfer = m_ov && rdy;
      done = 0;
      s    = 0;
      if (cv && m_have && m_grp.size() != 0) begin
         m_err = 1;
         if (v) m_grp.push_back(d);
      end else if (cv) begin
         m_have = 1;
         m_len  = ((cl & 255) == 0) ? 256 : (cl & 255);
         m_grp.delete();
      end else if (m_have && v) begin
         m_grp.push_back(d);
      end
      if (m_have && m_grp.size() == m_len) begin
         foreach (m_grp[i]) s += m_grp[i];
         done = 1;
         m_grp.delete();
      end
      if (done) begin
         if (!m_ov || xfer) begin
            m_ov = 1;
            m_od = s[31:0];
         end else begin
            m_err = 1;
         end
      end else if (xfer) begin
         m_ov = 0;
      end
   endtask

   // One clock: drive at negedge, let the edge happen, compare at the next negedge.
   task automatic step(bit r, bit cv, int cl, bit v, int unsigned d, bit rdy);
      rst             = r;
      bus.i_cfg_valid = cv;
      bus.i_cfg_len   = 8'(cl);
      bus.i_valid     = v;
      bus.i_data      = 24'(d);
      bus.i_ready     = rdy;
      @(posedge clk);
      model_edge(r, cv, cl, v, d, rdy);
      @(negedge clk);
      chk("o_valid", bus.o_valid, m_ov);
      chk("o_data",  bus.o_data,  m_od);
      chk("o_busy",  bus.o_busy,  m_grp.size() != 0);
      chk("o_err",   bus.o_err,   m_err);
   endtask

   task automatic idle(bit rdy);
      step(0, 0, 0, 0, 0, rdy);
   endtask

   task automatic prod(int unsigned d, bit rdy);
      step(0, 0, 0, 1, d, rdy);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int unsigned vals[3];
      m_have = 0; m_len = 0; m_ov = 0; m_od = 0; m_err = 0;
      rst = 1'b1;
      bus.i_cfg_valid = 0; bus.i_cfg_len = 0; bus.i_valid = 0;
      bus.i_data = 0; bus.i_ready = 0;

      // Reset state.
      do_reset();
      chk("rst_o_valid", bus.o_valid, 0);
      chk("rst_o_data",  bus.o_data,  0);
      chk("rst_o_err",   bus.o_err,   0);
      prod(9, 1);
      chk("idle_ignores_product", bus.o_busy, 0);

      // len=4, 10+20+30+40.
      step(0, 1, 4, 0, 0, 1);
      prod(10, 1); prod(20, 1); prod(30, 1);
      chk("len4_busy", bus.o_busy, 1);
      prod(40, 1);
      chk("len4_valid", bus.o_valid, 1);
      chk("len4_sum",   bus.o_data,  100);
      chk("len4_idle",  bus.o_busy,  0);
      idle(1);
      chk("len4_one_cycle", bus.o_valid, 0);

      // len=2 with a stalled consumer: second group dropped.
      do_reset();
      step(0, 1, 2, 0, 0, 0);
      prod(5, 0); prod(6, 0);
      chk("stall_sum", bus.o_data, 11);
      prod(7, 0);
      chk("stall_no_err_yet", bus.o_err, 0);
      prod(8, 0);
      chk("stall_err",  bus.o_err,  1);
      chk("stall_held", bus.o_data, 11);
      idle(1);
      chk("stall_drained", bus.o_valid, 0);

      // len=0 means 256 products.
      do_reset();
      step(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 255; i++) prod(65025, 1);
      chk("len256_not_done", bus.o_valid, 0);
      prod(65025, 1);
      chk("len256_valid", bus.o_valid, 1);
      chk("len256_sum",   bus.o_data,  16646400);

      // Mid-group config is ignored and flagged.
      do_reset();
      step(0, 1, 3, 0, 0, 1);
      prod(7, 1); prod(8, 1);
      step(0, 1, 1, 0, 0, 1);
      chk("midcfg_err",  bus.o_err,  1);
      chk("midcfg_busy", bus.o_busy, 1);
      prod(9, 1);
      chk("midcfg_valid", bus.o_valid, 1);
      chk("midcfg_sum",   bus.o_data,  24);

      // Config and product together at count 0: config wins.
      step(0, 1, 2, 1, 50, 1);
      chk("cfg_wins_busy", bus.o_busy, 0);

      // Reset on the completion edge discards everything, length lost.
      do_reset();
      step(0, 1, 2, 0, 0, 1);
      prod(1, 1);
      step(1, 0, 0, 1, 2, 1);
      chk("rst_edge_valid", bus.o_valid, 0);
      prod(1, 1); prod(2, 1); prod(3, 1);
      chk("no_len_after_rst", bus.o_valid, 0);

      // len=1, back-to-back results.
      do_reset();
      step(0, 1, 1, 0, 0, 1);
      vals[0] = 3; vals[1] = 4; vals[2] = 5;
      for (int i = 0; i < 3; i++) begin
         prod(vals[i], 1);
         chk("len1_valid", bus.o_valid, 1);
         chk("len1_data",  bus.o_data,  vals[i]);
      end
      idle(1);
      chk("len1_err", bus.o_err, 0);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         bit          r, cv, v, rdy;
         int          cl;
         int unsigned d;
         r   = ($urandom_range(0, 299) == 0);
         cv  = ($urandom_range(0, 29) == 0);
         cl  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 6);
         v   = ($urandom_range(0, 9) < 6);
         d   = $urandom & 32'h00FF_FFFF;
         rdy = ($urandom_range(0, 9) < 7);
         step(r, cv, cl, v, d, rdy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001: Parameter IN_W, default 24, width of the incoming multiplier product.
REQ-002: Parameter ACC_W, default 32, width of the accumulator and result.
REQ-003: Parameter LEN_W, default 8, width of the group-length field.
REQ-004: clk  input  1  single clock; all state updates on posedge clk.
REQ-005: rst  input  1  synchronous, active-high reset.
REQ-006: i_cfg_valid  input  1  strobe that loads a new group length.
REQ-007: i_cfg_len  input  LEN_W  products per group; value 0 means 2^LEN_W.
REQ-008: i_valid  input  1  product valid, driven by an upstream multiplier switch; no backpressure.
REQ-009: i_data  input  IN_W  unsigned product, sampled only when i_valid=1.
REQ-010: o_valid  output  1  result register holds an unconsumed result.
REQ-011: o_data  output  ACC_W  completed group sum.
REQ-012: i_ready  input  1  downstream accept; transfer occurs when o_valid=1 and i_ready=1.
REQ-013: o_busy  output  1  a group is partially accumulated (count != 0).
REQ-014: o_err  output  1  sticky: a completed group was dropped, or a config arrived mid-group.

Function
REQ-015: The block SHALL implement states IDLE (no length loaded) and RUN (length loaded); the state SHALL be RUN whenever a valid length is held.
REQ-016: In IDLE, i_valid SHALL be ignored; products SHALL NOT be accumulated.
REQ-017: i_cfg_valid SHALL be accepted in IDLE, or in RUN with count=0; acceptance SHALL latch the length, clear count and acc, and enter RUN on the next cycle.
REQ-018: i_cfg_valid in RUN with count!=0 SHALL be ignored, the group SHALL continue unchanged, and o_err SHALL be set.
REQ-019: If i_cfg_valid and i_valid coincide with count=0 in RUN, the config SHALL win and the product SHALL be discarded.
REQ-020: In RUN, each i_valid SHALL add the zero-extended i_data to acc and increment count.
REQ-021: When the product that makes count equal the length is accepted, sum=acc+i_data SHALL be offered to the result register; acc and count SHALL clear in the same edge, so a product on the next cycle starts a new group.
REQ-022: Latency: a final product accepted at edge N SHALL give o_valid=1 and o_data=sum after edge N, with no bubble between groups.
REQ-023: o_valid and o_data SHALL stay stable until a transfer occurs; after a transfer with no new sum, o_valid SHALL fall at the next edge.
REQ-024: Transfer and new sum on the same edge SHALL load the new sum and keep o_valid=1.
REQ-025: New sum with o_valid=1 and no transfer SHALL be dropped; the old result SHALL be kept and o_err SHALL be set.
REQ-026: Arithmetic SHALL be unsigned and modulo 2^ACC_W; with defaults no wrap is reachable (256x65025 < 2^24).
REQ-027: Length 1 SHALL produce a result for every accepted product.
REQ-028: o_busy SHALL be combinational (count != 0).

Reset
REQ-029: While rst=1: o_valid=0, o_data=0, o_err=0, acc=0, count=0, length=0, state=IDLE; all other inputs SHALL be ignored.
REQ-030: rst mid-group or with a held result SHALL discard both; no result SHALL be emitted after reset.
REQ-031: The length SHALL NOT survive reset; a new i_cfg_valid SHALL be required.

Verification
REQ-032: cfg len=4; products 10,20,30,40 on consecutive cycles, i_ready=1 -> o_valid=1 for exactly one cycle, o_data=100, one cycle after the 40; o_busy=0 afterwards.
REQ-033: len=2, i_ready=0; products 5,6,7,8 -> o_data=11 held; o_err=1 after the 8th product's group completes; then raise i_ready -> 11 transferred, o_valid falls.
REQ-034: len=0 (256); 256 products of 65025 -> o_data=16646400; no wrap.
REQ-035: len=3; after 2 products assert i_cfg_valid len=1 -> o_err=1, group ends on the 3rd product with the correct sum.
REQ-036: len=2; products 1,2 then rst on the completion edge -> o_valid=0, state IDLE; later products with no config -> no o_valid.
REQ-037: len=1, i_ready=1; products 3,4,5 back-to-back -> o_valid high for 3 cycles with o_data 3,4,5; o_err stays 0.
